sync_fifo_ctl: RTL

Single-clock, parametrised FIFO. It generalises the existing controller FIFO with the following additions:
- arbitrary (non-power-of-2) depth
- selectable first-word-fall-through read mode
- fill count and programmable almost-full/almost-empty flags
- synchronous flush
- sticky overflow/underflow error flags

It sits between the serial/command front-end and the processor interface, buffering command and data words across rate mismatches.

---
 rtl/sync_fifo_ctl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with arbitrary depth, optional first-word
// fall-through, fill level, almost flags, synchronous flush and sticky errors.
module sync_fifo_ctl #(
  parameter int DEPTH         = 8,
  parameter int WIDTH         = 8,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           write_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           read_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Pointers wrap explicitly so non-power-of-2 depths index correctly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) begin
      return ptr_t'(0);
    end else begin
      return p + ptr_t'(1);
    end
  endfunction

  function automatic logic is_full(input cnt_t c);
    return (c == cnt_t'(DEPTH));
  endfunction

  function automatic logic is_empty(input cnt_t c);
    return (c == cnt_t'(0));
  endfunction

  function automatic logic is_afull(input cnt_t c);
    return (int'(c) >= AFULL_THRESH);
  endfunction

  function automatic logic is_aempty(input cnt_t c);
    return (int'(c) <= AEMPTY_THRESH);
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];

  ptr_t wr_ptr_r, wr_ptr_s;
  ptr_t rd_ptr_r, rd_ptr_s;
  cnt_t count_r, count_s;
  logic overflow_r, overflow_s;
  logic underflow_r, underflow_s;
  logic full_r, empty_r, afull_r, aempty_r;
  logic wr_ok_s, rd_ok_s;

  // Next-state for pointers, count and sticky errors; flush overrides requests.
  always_comb begin
    wr_ok_s     = 1'b0;
    rd_ok_s     = 1'b0;
    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    count_s     = count_r;
    overflow_s  = overflow_r;
    underflow_s = underflow_r;
    if (flush_i) begin
      wr_ptr_s    = ptr_t'(0);
      rd_ptr_s    = ptr_t'(0);
      count_s     = cnt_t'(0);
      overflow_s  = 1'b0;
      underflow_s = 1'b0;
    end else begin
      wr_ok_s = wr_en_i && !full_r;
      rd_ok_s = rd_en_i && !empty_r;
      if (wr_ok_s) begin
        wr_ptr_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (rd_ok_s) begin
        rd_ptr_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_s = count_r + cnt_t'(1);
        2'b01:   count_s = count_r - cnt_t'(1);
        default: count_s = count_r;
      endcase
      overflow_s  = overflow_r | (wr_en_i & full_r);
      underflow_s = underflow_r | (rd_en_i & empty_r);
    end
  end

  // Control state and status flags, flags decoded from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= ptr_t'(0);
      rd_ptr_r    <= ptr_t'(0);
      count_r     <= cnt_t'(0);
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      full_r      <= is_full(cnt_t'(0));
      empty_r     <= is_empty(cnt_t'(0));
      afull_r     <= is_afull(cnt_t'(0));
      aempty_r    <= is_aempty(cnt_t'(0));
    end else begin
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      count_r     <= count_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
      full_r      <= is_full(count_s);
      empty_r     <= is_empty(count_s);
      afull_r     <= is_afull(count_s);
      aempty_r    <= is_aempty(count_s);
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= write_data_i;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign read_data_o = mem_r[rd_ptr_r];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_r;

      // Registered read port: loads on an accepted pop, otherwise holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_r <= '0;
        end else if (flush_i) begin
          rd_data_r <= '0;
        end else if (rd_ok_s) begin
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end

      assign read_data_o = rd_data_r;
    end
  endgenerate

  assign full_o         = full_r;
  assign empty_o        = empty_r;
  assign almost_full_o  = afull_r;
  assign almost_empty_o = aempty_r;
  assign count_o        = count_r;
  assign overflow_o     = overflow_r;
  assign underflow_o    = underflow_r;

endmodule
